// File: rtl/reg_bank_incdec.sv
// Counter/pointer register bank: DEPTH registers of WIDTH bits with one load
// port, one inc/dec port, two combinational read ports, a zero flag on port A,
// a one-cycle carry/borrow pulse and a sticky overflow flag.
module reg_bank_incdec #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SAT       = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] D,
  input  logic             inc,
  input  logic             dec,
  input  logic [AW-1:0]    isel,
  input  logic             clr_ovf,
  input  logic [AW-1:0]    rsel_a,
  output logic [WIDTH-1:0] Q_a,
  input  logic [AW-1:0]    rsel_b,
  output logic [WIDTH-1:0] Q_b,
  output logic             zero_a,
  output logic             cy,
  output logic             ovf
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0] DepthW = DEPTH[AW:0];

  logic [WIDTH-1:0] regs_q [DEPTH];

  logic             wsel_ok;
  logic             isel_ok;
  logic             load_hits_isel;
  logic             step_en;
  logic [WIDTH-1:0] cur;
  logic             at_max;
  logic             at_min;
  logic             step_evt;
  logic [WIDTH-1:0] step_val;

  // Address range checks; only matter for non-power-of-two DEPTH.
  always_comb begin
    wsel_ok        = ({1'b0, wsel} < DepthW);
    isel_ok        = ({1'b0, isel} < DepthW);
    load_hits_isel = set && wsel_ok && (wsel == isel);
  end

  // Read muxes and the inc/dec operand; unmapped addresses read as zero.
  always_comb begin
    Q_a = '0;
    Q_b = '0;
    cur = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rsel_a == AW'(i)) Q_a = regs_q[i];
      if (rsel_b == AW'(i)) Q_b = regs_q[i];
      if (isel == AW'(i))   cur = regs_q[i];
    end
    zero_a = (Q_a == '0);
  end

  // Inc/dec result and boundary event; a load to the same register cancels it.
  always_comb begin
    step_en  = (inc ^ dec) && isel_ok && !load_hits_isel;
    at_max   = (cur == {WIDTH{1'b1}});
    at_min   = (cur == '0);
    step_evt = 1'b0;
    step_val = cur;
    if (step_en) begin
      if (inc) begin
        step_evt = at_max;
        if (at_max) step_val = (SAT != 0) ? cur : '0;
        else        step_val = cur + WIDTH'(1);
      end else begin
        step_evt = at_min;
        if (at_min) step_val = (SAT != 0) ? cur : {WIDTH{1'b1}};
        else        step_val = cur - WIDTH'(1);
      end
    end
  end

  // Register bank update: reset, then load, then inc/dec on a different entry.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst) begin
        regs_q[i] <= RESET_VAL;
      end else if (set && (wsel == AW'(i))) begin
        regs_q[i] <= D;
      end else if (step_en && (isel == AW'(i))) begin
        regs_q[i] <= step_val;
      end
    end
  end

  // Event flags: cy is a single-cycle pulse, ovf is sticky until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      cy  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cy  <= step_evt;
      ovf <= step_evt | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_reg_bank_incdec.sv
// Bench for reg_bank_incdec: a wrap bank, a saturating bank and a DEPTH=3/WIDTH=5
// wrap bank share one stimulus stream and are each checked against an array model.
module tb_reg_bank_incdec;

  logic       clk = 1'b0;
  logic       rst, set, inc, dec, clr_ovf;
  logic [1:0] wsel, isel, rsel_a, rsel_b;
  logic [5:0] d;

  logic [5:0] qa0, qb0, qa1, qb1;
  logic [4:0] qa2, qb2;
  logic       z0, z1, z2, cy0, cy1, cy2, ov0, ov1, ov2;

  int ncmp  = 0;
  int nfail = 0;

  // Model state, one row per instance.
  int unsigned mreg [3][4];
  bit          mcy  [3];
  bit          movf [3];
  int unsigned mw   [3] = '{6, 6, 5};
  int unsigned md   [3] = '{4, 4, 3};
  bit          ms   [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  reg_bank_incdec #(.WIDTH(6), .DEPTH(4), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .set(set), .wsel(wsel), .D(d), .inc(inc), .dec(dec),
    .isel(isel), .clr_ovf(clr_ovf), .rsel_a(rsel_a), .Q_a(qa0), .rsel_b(rsel_b),
    .Q_b(qb0), .zero_a(z0), .cy(cy0), .ovf(ov0)
  );

  reg_bank_incdec #(.WIDTH(6), .DEPTH(4), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .set(set), .wsel(wsel), .D(d), .inc(inc), .dec(dec),
    .isel(isel), .clr_ovf(clr_ovf), .rsel_a(rsel_a), .Q_a(qa1), .rsel_b(rsel_b),
    .Q_b(qb1), .zero_a(z1), .cy(cy1), .ovf(ov1)
  );

  reg_bank_incdec #(.WIDTH(5), .DEPTH(3), .SAT(0)) dut_n (
    .clk(clk), .rst(rst), .set(set), .wsel(wsel), .D(d[4:0]), .inc(inc), .dec(dec),
    .isel(isel), .clr_ovf(clr_ovf), .rsel_a(rsel_a), .Q_a(qa2), .rsel_b(rsel_b),
    .Q_b(qb2), .zero_a(z2), .cy(cy2), .ovf(ov2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qa_of(input int k);
    case (k)
      0:       return {26'b0, qa0};
      1:       return {26'b0, qa1};
      default: return {27'b0, qa2};
    endcase
  endfunction

  function automatic logic [31:0] qb_of(input int k);
    case (k)
      0:       return {26'b0, qb0};
      1:       return {26'b0, qb1};
      default: return {27'b0, qb2};
    endcase
  endfunction

  function automatic logic [31:0] z_of(input int k);
    case (k)
      0:       return {31'b0, z0};
      1:       return {31'b0, z1};
      default: return {31'b0, z2};
    endcase
  endfunction

  function automatic logic [31:0] cy_of(input int k);
    case (k)
      0:       return {31'b0, cy0};
      1:       return {31'b0, cy1};
      default: return {31'b0, cy2};
    endcase
  endfunction

  function automatic logic [31:0] ov_of(input int k);
    case (k)
      0:       return {31'b0, ov0};
      1:       return {31'b0, ov1};
      default: return {31'b0, ov2};
    endcase
  endfunction

  function automatic int unsigned mread(input int k, input int unsigned a);
    return (a < md[k]) ? mreg[k][a] : 0;
  endfunction

  // Reference behaviour applied at a clock edge using the inputs held across it.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int unsigned mx = (1 << mw[k]) - 1;
      bit ev = 1'b0;
      bit do_step = 1'b0;
      int unsigned nv = 0;
      if (rst) begin
        for (int i = 0; i < 4; i++) mreg[k][i] = 0;
        mcy[k]  = 1'b0;
        movf[k] = 1'b0;
      end else begin
        if ((inc != dec) && (isel < md[k]) && !(set && wsel == isel)) begin
          int unsigned v = mreg[k][isel];
          do_step = 1'b1;
          if (inc) begin
            if (v == mx) begin ev = 1'b1; nv = ms[k] ? mx : 0; end
            else nv = v + 1;
          end else begin
            if (v == 0) begin ev = 1'b1; nv = ms[k] ? 0 : mx; end
            else nv = v - 1;
          end
        end
        if (set && (wsel < md[k])) mreg[k][wsel] = d & mx;
        if (do_step) mreg[k][isel] = nv;
        mcy[k]  = ev;
        movf[k] = ev ? 1'b1 : (clr_ovf ? 1'b0 : movf[k]);
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [1:0] ws, input logic [5:0] dd,
                      input bit i, input bit dc, input logic [1:0] is, input bit c);
    rst = r; set = s; wsel = ws; d = dd; inc = i; dec = dc; isel = is; clr_ovf = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    rsel_a = a;
    rsel_b = b;
    #1;
  endtask

  // Compare every instance against the model for the current read addresses.
  task automatic check_point(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_qa%0d", tag, k), qa_of(k), mread(k, rsel_a));
      chk($sformatf("%s_qb%0d", tag, k), qb_of(k), mread(k, rsel_b));
      chk($sformatf("%s_z%0d", tag, k), z_of(k), (mread(k, rsel_a) == 0) ? 1 : 0);
      chk($sformatf("%s_cy%0d", tag, k), cy_of(k), 32'(mcy[k]));
      chk($sformatf("%s_ov%0d", tag, k), ov_of(k), 32'(movf[k]));
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), 2'(3 - a));
      check_point(tag);
    end
  endtask

  initial begin
    rst = 1'b1; set = 1'b0; wsel = '0; d = '0; inc = 1'b0; dec = 1'b0; isel = '0;
    clr_ovf = 1'b0; rsel_a = '0; rsel_b = '0;

    // Reset and loads.
    step(1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    sweep("reset");
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), 2'(a));
      chk("reset_q", {26'b0, qa0}, 0);
      chk("reset_z", {31'b0, z0}, 1);
    end
    step(1'b0, 1'b1, 2'd1, 6'd61, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 6'd27, 1'b0, 1'b0, 2'd0, 1'b0);
    rd(2'd1, 2'd2);
    chk("load_qa", {26'b0, qa0}, 61);
    chk("load_qb", {26'b0, qb0}, 27);
    chk("load_cy", {31'b0, cy0}, 0);
    chk("load_ov", {31'b0, ov0}, 0);
    chk("load_qa_w5", {27'b0, qa2}, 29);
    sweep("load");

    // Wrap on the wrap bank, saturate on the saturating bank.
    step(1'b0, 1'b1, 2'd0, 6'd63, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    rd(2'd0, 2'd1);
    chk("wrap_q", {26'b0, qa0}, 0);
    chk("wrap_z", {31'b0, z0}, 1);
    chk("wrap_cy", {31'b0, cy0}, 1);
    chk("wrap_ov", {31'b0, ov0}, 1);
    chk("sat_inc_q0", {26'b0, qa1}, 63);
    chk("sat_inc_cy0", {31'b0, cy1}, 1);
    idle();
    chk("wrap_cy_drop", {31'b0, cy0}, 0);
    chk("wrap_ov_hold", {31'b0, ov0}, 1);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("unwrap_q", {26'b0, qa0}, 63);
    chk("unwrap_cy", {31'b0, cy0}, 1);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("clr_ov", {31'b0, ov0}, 0);
    sweep("wrap");

    // Saturation on reg3.
    step(1'b0, 1'b1, 2'd3, 6'd63, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 2'd3, 1'b0);
    rd(2'd3, 2'd0);
    chk("sat1_q", {26'b0, qa1}, 63);
    chk("sat1_cy", {31'b0, cy1}, 1);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 2'd3, 1'b0);
    chk("sat2_q", {26'b0, qa1}, 63);
    chk("sat2_cy", {31'b0, cy1}, 1);
    chk("sat2_ov", {31'b0, ov1}, 1);
    step(1'b0, 1'b1, 2'd3, 6'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("sat_clr_ov", {31'b0, ov1}, 0);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("satlo_q", {26'b0, qa1}, 0);
    chk("satlo_cy", {31'b0, cy1}, 1);
    chk("satlo_ov", {31'b0, ov1}, 1);
    sweep("sat");

    // Collisions between the load and inc/dec ports.
    step(1'b0, 1'b1, 2'd2, 6'd15, 1'b1, 1'b0, 2'd2, 1'b0);
    rd(2'd2, 2'd1);
    chk("coll_same_q", {26'b0, qa0}, 15);
    chk("coll_same_cy", {31'b0, cy0}, 0);
    step(1'b0, 1'b1, 2'd2, 6'd15, 1'b1, 1'b0, 2'd1, 1'b0);
    chk("coll_diff_q2", {26'b0, qa0}, 15);
    chk("coll_diff_q1", {26'b0, qb0}, 62);
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("incdec_q", {26'b0, qb0}, 62);
    chk("incdec_cy", {31'b0, cy0}, 0);
    sweep("coll");

    // Reset mid-operation with a pending overflow.
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("pre_rst_ov", {31'b0, ov0}, 1);
    step(1'b1, 1'b1, 2'd1, 6'd5, 1'b1, 1'b0, 2'd2, 1'b0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), 2'(3 - a));
      chk("midrst_q", {26'b0, qa0}, 0);
    end
    chk("midrst_cy", {31'b0, cy0}, 0);
    chk("midrst_ov", {31'b0, ov0}, 0);
    sweep("midrst");
    step(1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 2'd0, 1'b1);
    chk("clr_vs_evt_ov", {31'b0, ov0}, 1);
    chk("clr_vs_evt_cy", {31'b0, cy0}, 1);

    // Out-of-range addresses on the DEPTH=3 bank.
    step(1'b0, 1'b1, 2'd3, 6'd9, 1'b1, 1'b0, 2'd3, 1'b0);
    rd(2'd3, 2'd3);
    chk("oor_q", {27'b0, qa2}, 0);
    chk("oor_cy", {31'b0, cy2}, 0);
    sweep("oor");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(31) == 0), 1'($urandom), 2'($urandom), 6'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(7) == 0));
      rd(2'($urandom), 2'($urandom));
      check_point("rand");
      if (n % 50 == 49) sweep("rand_sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
